gmii_tx_packet_fifo: RTL

Store-and-forward AXI-Stream packet buffer that sits directly upstream of the GMII transmit MAC. The MAC needs each frame presented with `tvalid` held high from first beat to `tlast`. This block guarantees that by releasing a packet only once it is completely stored. Packets that overflow the buffer, or that are flagged bad by upstream on their `tlast` beat, are discarded whole; the MAC never sees them.

---
 rtl/gmii_tx_packet_fifo.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gmii_tx_packet_fifo.sv
// Store-and-forward AXI-Stream packet buffer feeding a GMII transmit MAC.
// A packet is released only after its tlast is stored; overflowing or bad packets are discarded.
module gmii_tx_packet_fifo #(
    parameter int unsigned AXIS_BYTES = 1,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned CTR_W      = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    sreset,
    input  logic                    axis_i_tvalid,
    output logic                    axis_i_tready,
    input  logic [8*AXIS_BYTES-1:0] axis_i_tdata,
    input  logic [AXIS_BYTES-1:0]   axis_i_tkeep,
    input  logic                    axis_i_tlast,
    input  logic                    axis_i_tuser,
    output logic                    axis_o_tvalid,
    input  logic                    axis_o_tready,
    output logic [8*AXIS_BYTES-1:0] axis_o_tdata,
    output logic [AXIS_BYTES-1:0]   axis_o_tkeep,
    output logic                    axis_o_tlast,
    output logic [CTR_W-1:0]        pkt_count,
    output logic                    drop_overflow,
    output logic                    drop_error
);

    localparam int unsigned DataW = 8 * AXIS_BYTES;
    localparam int unsigned WordW = DataW + AXIS_BYTES + 1;
    localparam int unsigned AddrW = CTR_W - 1;

    typedef enum logic [0:0] {StAccept, StDrop} wr_state_e;

    logic [WordW-1:0] mem [DEPTH];
    logic [WordW-1:0] rd_word_q;
    logic [WordW-1:0] wr_word;

    wr_state_e        state_q, state_d;
    logic [CTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [CTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic             o_valid_q, o_valid_d;
    logic             dov_q, dov_d;
    logic             derr_q, derr_d;

    logic accept;
    logic out_fire;
    logic rd_en;
    logic wr_en;
    logic full;
    logic commit;
    logic release_pkt;

    assign axis_i_tready = ~sreset;
    assign accept        = axis_i_tvalid & axis_i_tready;
    assign out_fire      = o_valid_q & axis_o_tready;
    assign rd_en         = (rd_ptr_q != commit_ptr_q) & (~o_valid_q | axis_o_tready);
    assign release_pkt   = out_fire & rd_word_q[WordW-1];
    assign wr_word       = {axis_i_tlast, axis_i_tkeep, axis_i_tdata};

    // A read issued this cycle frees its slot; the RAM is read-first so the overlap is safe.
    assign full = ((wr_ptr_q - rd_ptr_q) == CTR_W'(DEPTH)) & ~rd_en;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_en        = 1'b0;
        commit       = 1'b0;
        dov_d        = 1'b0;
        derr_d       = 1'b0;
        unique case (state_q)
            StAccept: begin
                if (accept && !full) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + CTR_W'(1);
                    if (axis_i_tlast) begin
                        if (axis_i_tuser) begin
                            wr_ptr_d = commit_ptr_q;
                            derr_d   = 1'b1;
                        end else begin
                            commit_ptr_d = wr_ptr_q + CTR_W'(1);
                            commit       = 1'b1;
                        end
                    end
                end else if (accept) begin
                    wr_ptr_d = commit_ptr_q;
                    if (axis_i_tlast) begin
                        dov_d = 1'b1;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StDrop: begin
                if (accept && axis_i_tlast) begin
                    dov_d   = 1'b1;
                    state_d = StAccept;
                end
            end
            default: state_d = StAccept;
        endcase
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        o_valid_d = o_valid_q;
        cnt_d     = cnt_q;
        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + CTR_W'(1);
            o_valid_d = 1'b1;
        end else if (out_fire) begin
            o_valid_d = 1'b0;
        end
        unique case ({commit, release_pkt})
            2'b10:   cnt_d = cnt_q + CTR_W'(1);
            2'b01:   cnt_d = cnt_q - CTR_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AddrW-1:0]] <= wr_word;
        end
        if (rd_en) begin
            rd_word_q <= mem[rd_ptr_q[AddrW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q      <= StAccept;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            o_valid_q    <= 1'b0;
            dov_q        <= 1'b0;
            derr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            o_valid_q    <= o_valid_d;
            dov_q        <= dov_d;
            derr_q       <= derr_d;
        end
    end

    assign axis_o_tvalid = o_valid_q;
    assign axis_o_tdata  = rd_word_q[DataW-1:0];
    assign axis_o_tkeep  = rd_word_q[DataW +: AXIS_BYTES];
    assign axis_o_tlast  = rd_word_q[WordW-1];
    assign pkt_count     = cnt_q;
    assign drop_overflow = dov_q;
    assign drop_error    = derr_q;

endmodule
